// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer: load/enable/mode in, count/tc/busy out.
interface down_counter_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;

    modport master (
        output load, load_val, en, auto_reload,
        input  count, tc, busy
    );

    modport slave (
        input  load, load_val, en, auto_reload,
        output count, tc, busy
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable synchronous down-counter/timer with one-shot or auto-reload mode
// and a single-cycle registered terminal-count pulse.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    down_counter_timer_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    // A load always wins over the terminal event, so a restart never emits tc.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = bus.load_val;
            rld_d   = bus.load_val;
            state_d = (bus.load_val != '0) ? RUN : IDLE;
        end else if (state_q == RUN && bus.en) begin
            if (count_q == ONE) begin
                tc_d = 1'b1;
                if (bus.auto_reload) begin
                    count_d = rld_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = (state_q == RUN);
endmodule
